// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-organised data memory. Sub-word stores
// become read-modify-write full-word writes; loads are lane-extracted and
// sign/zero-extended; misaligned or illegal requests complete without any
// memory access.
module lsu_rmw #(
  parameter int width     = 32,
  parameter int addrWidth = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_func3,
  input  logic [31:0]          req_addr,
  input  logic [width-1:0]     req_wdata,
  output logic                 rsp_valid,
  output logic [width-1:0]     rsp_rdata,
  output logic                 rsp_misaligned,
  output logic [addrWidth-1:0] mem_addr,
  output logic [width-1:0]     mem_din,
  output logic                 mem_wren,
  output logic [2:0]           mem_func3,
  input  logic [width-1:0]     mem_dout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   we_q, we_d;
  logic [2:0]             func3_q, func3_d;
  logic [addrWidth+1:0]   addr_q, addr_d;
  logic [width-1:0]       wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic [width-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic [width-1:0]       mem_din_q, mem_din_d;
  logic                   unused_addr_bits;

  // Address bits above the memory index are deliberately dropped (wrap-around).
  assign unused_addr_bits = ^req_addr[31:addrWidth+2];

  // Illegal funct3 for the direction, or a half/word not naturally aligned.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] lane);
    logic illegal;
    logic misaligned;
    if (we) illegal = (f3 > 3'b010);
    else    illegal = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((f3[1:0] == 2'b01) && lane[0]) ||
                 ((f3[1:0] == 2'b10) && (lane != 2'b00));
    return illegal || misaligned;
  endfunction

  // Pick the addressed lane out of a little-endian word and extend it.
  function automatic logic [width-1:0] extract(input logic [width-1:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Overlay the store data onto the word read from memory.
  function automatic logic [width-1:0] merge(input logic [width-1:0] word,
                                             input logic [width-1:0] wd,
                                             input logic [2:0] f3,
                                             input logic [1:0] lane);
    logic [width-1:0] m;
    m = word;
    if (f3 == 3'b000) begin
      case (lane)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (f3 == 3'b001) begin
      if (lane[1]) m[31:16] = wd[15:0];
      else         m[15:0]  = wd[15:0];
    end else begin
      m = wd;
    end
    return m;
  endfunction

  // Next-state, request latching and response/write-word staging.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_din_d   = mem_din_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          func3_d = req_func3;
          addr_d  = req_addr[addrWidth+1:0];
          wdata_d = req_wdata;
          err_d   = access_err(req_we, req_func3, req_addr[1:0]);
          if (err_d) begin
            rsp_rdata_d = '0;
            state_d     = RESP;
          end else if (req_we && (req_func3 == 3'b010)) begin
            mem_din_d = req_wdata;
            state_d   = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          mem_din_d = merge(mem_dout, wdata_q, func3_q, addr_q[1:0]);
          state_d   = WRITE;
        end else begin
          rsp_rdata_d = extract(mem_dout, func3_q, addr_q[1:0]);
          state_d     = RESP;
        end
      end
      WRITE: begin
        rsp_rdata_d = '0;
        state_d     = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, address and output registers; cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      err_q       <= 1'b0;
      rsp_rdata_q <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_din_q   <= mem_din_d;
    end
  end

  // Latched request payload; only meaningful after an acceptance.
  always_ff @(posedge clock) begin
    we_q    <= we_d;
    func3_q <= func3_d;
    wdata_q <= wdata_d;
  end

  assign req_ready      = (state_q == IDLE);
  assign rsp_valid      = (state_q == RESP);
  assign rsp_misaligned = (state_q == RESP) && err_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign mem_addr       = addr_q[addrWidth+1:2];
  assign mem_din        = mem_din_q;
  assign mem_wren       = (state_q == WRITE) && !reset;
  assign mem_func3      = 3'b010;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a behavioural word memory behind it.
module tb_lsu_rmw;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_wren;
  logic [2:0]  mem_func3;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:255];
  int total = 0;
  int bad = 0;

  lsu_rmw #(.width(32), .addrWidth(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misaligned(rsp_misaligned),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren),
    .mem_func3(mem_func3), .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  assign mem_dout = mem[mem_addr];

  always @(posedge clock) if (mem_wren) mem[mem_addr] <= mem_din;

  // Issue one request from an IDLE negedge and observe until the response.
  // Returns at a negedge in the IDLE cycle after the response.
  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata,
                         output logic mis, output int nwr,
                         output logic [7:0] waddr, output logic [31:0] wdin,
                         output int wr_lat);
    lat = 0; rdata = 32'd0; mis = 1'b0; nwr = 0;
    waddr = 8'd0; wdin = 32'd0; wr_lat = 0;
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_we = ~we; req_func3 = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (mem_wren) begin
        nwr++; waddr = mem_addr; wdin = mem_din; wr_lat = k;
      end
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; mis = rsp_misaligned;
        break;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
    total++; if (rsp_misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%b want=0", rsp_misaligned); end
    total++; if (mem_addr !== 8'd0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    total++; if (mem_din !== 32'd0) begin bad++; $display("FAIL reset_mem_din got=%h want=0", mem_din); end
    total++; if (mem_wren !== 1'b0) begin bad++; $display("FAIL reset_mem_wren got=%b want=0", mem_wren); end
    total++; if (mem_func3 !== 3'b010) begin bad++; $display("FAIL reset_mem_func3 got=%b want=010", mem_func3); end
    reset = 1'b0;
    @(negedge clock);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_loads;
    logic [31:0] addrs [6] = '{32'h5, 32'h6, 32'h6, 32'h6, 32'h6, 32'h4};
    logic [2:0]  f3s   [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] exps  [6] = '{32'h0000007F, 32'hFFFFFFF1, 32'h000000F1,
                               32'hFFFF80F1, 32'h000080F1, 32'h80F17F22};
    int lat, nwr, wl; logic [31:0] rd, wdin; logic mis; logic [7:0] wa;
    for (int i = 0; i < 6; i++) begin
      run_req(1'b0, f3s[i], addrs[i], 32'd0, lat, rd, mis, nwr, wa, wdin, wl);
      total++; if (rd !== exps[i]) begin bad++; $display("FAIL load%0d_data got=%h want=%h", i, rd, exps[i]); end
      total++; if (lat != 2) begin bad++; $display("FAIL load%0d_latency got=%0d want=2", i, lat); end
      total++; if (mis !== 1'b0) begin bad++; $display("FAIL load%0d_misaligned got=%b want=0", i, mis); end
      total++; if (nwr != 0) begin bad++; $display("FAIL load%0d_writes got=%0d want=0", i, nwr); end
    end
  endtask

  task automatic test_stores;
    int lat, nwr, wl; logic [31:0] rd, wdin; logic mis; logic [7:0] wa;
    run_req(1'b1, 3'b000, 32'h7, 32'hDEADBEEF, lat, rd, mis, nwr, wa, wdin, wl);
    total++; if (nwr != 1) begin bad++; $display("FAIL sb_writes got=%0d want=1", nwr); end
    total++; if (wa !== 8'd1) begin bad++; $display("FAIL sb_mem_addr got=%h want=01", wa); end
    total++; if (wdin !== 32'hEFF17F22) begin bad++; $display("FAIL sb_mem_din got=%h want=eff17f22", wdin); end
    total++; if (lat != 3) begin bad++; $display("FAIL sb_latency got=%0d want=3", lat); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL sb_rdata got=%h want=0", rd); end
    run_req(1'b0, 3'b010, 32'h4, 32'd0, lat, rd, mis, nwr, wa, wdin, wl);
    total++; if (rd !== 32'hEFF17F22) begin bad++; $display("FAIL sb_readback got=%h want=eff17f22", rd); end
    run_req(1'b1, 3'b001, 32'h2, 32'h1234ABCD, lat, rd, mis, nwr, wa, wdin, wl);
    total++; if (wdin !== 32'hABCD3344) begin bad++; $display("FAIL sh_mem_din got=%h want=abcd3344", wdin); end
    total++; if (wa !== 8'd0) begin bad++; $display("FAIL sh_mem_addr got=%h want=00", wa); end
    total++; if (lat != 3) begin bad++; $display("FAIL sh_latency got=%0d want=3", lat); end
    run_req(1'b1, 3'b010, 32'h8, 32'hCAFEF00D, lat, rd, mis, nwr, wa, wdin, wl);
    total++; if (nwr != 1 || wl != 1) begin bad++; $display("FAIL sw_write got=%0d@%0d want=1@1", nwr, wl); end
    total++; if (wa !== 8'd2) begin bad++; $display("FAIL sw_mem_addr got=%h want=02", wa); end
    total++; if (wdin !== 32'hCAFEF00D) begin bad++; $display("FAIL sw_mem_din got=%h want=cafef00d", wdin); end
    total++; if (lat != 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", lat); end
    total++; if (mem[2] !== 32'hCAFEF00D) begin bad++; $display("FAIL sw_memory got=%h want=cafef00d", mem[2]); end
  endtask

  task automatic test_errors;
    logic        wes  [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] adrs [3] = '{32'h6, 32'h3, 32'h0};
    int lat, nwr, wl; logic [31:0] rd, wdin; logic mis; logic [7:0] wa;
    run_req(1'b0, 3'b010, 32'h0, 32'd0, lat, rd, mis, nwr, wa, wdin, wl);
    total++; if (rd !== 32'hABCD3344) begin bad++; $display("FAIL sh_readback got=%h want=abcd3344", rd); end
    for (int i = 0; i < 3; i++) begin
      run_req(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, lat, rd, mis, nwr, wa, wdin, wl);
      total++; if (mis !== 1'b1) begin bad++; $display("FAIL err%0d_misaligned got=%b want=1", i, mis); end
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL err%0d_rdata got=%h want=0", i, rd); end
      total++; if (nwr != 0) begin bad++; $display("FAIL err%0d_writes got=%0d want=0", i, nwr); end
      total++; if (lat != 1) begin bad++; $display("FAIL err%0d_latency got=%0d want=1", i, lat); end
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b000; req_addr = 32'h4; req_wdata = 32'h55;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    total++; if (mem_wren !== 1'b0) begin bad++; $display("FAIL abort_mem_wren got=%b want=0", mem_wren); end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_req_ready got=%b want=1", req_ready); end
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid === 1'b1 || mem_wren === 1'b1) seen++;
      @(negedge clock);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_activity got=%0d want=0", seen); end
    total++; if (mem[1] !== 32'hEFF17F22) begin bad++; $display("FAIL abort_memory got=%h want=eff17f22", mem[1]); end
  endtask

  task automatic test_back_to_back;
    int acc_cyc, rsp_n; int rsp_cyc [2]; logic [31:0] rsp_dat [2];
    acc_cyc = -1; rsp_n = 0; rsp_cyc = '{-1, -1}; rsp_dat = '{32'd0, 32'd0};
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h4;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_ready got=%b want=1", req_ready); end
    @(posedge clock);
    #1 req_addr = 32'h0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (req_ready && acc_cyc < 0) acc_cyc = c;
      if (rsp_valid && rsp_n < 2) begin rsp_cyc[rsp_n] = c; rsp_dat[rsp_n] = rsp_rdata; rsp_n++; end
      @(posedge clock);
      #1;
      if (c == acc_cyc) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    @(negedge clock);
    total++; if (acc_cyc != 3) begin bad++; $display("FAIL b2b_second_accept got=%0d want=3", acc_cyc); end
    total++; if (rsp_cyc[0] != 2 || rsp_cyc[1] != 5) begin bad++; $display("FAIL b2b_rsp_cycles got=%0d,%0d want=2,5", rsp_cyc[0], rsp_cyc[1]); end
    total++; if (rsp_dat[0] !== 32'hEFF17F22) begin bad++; $display("FAIL b2b_rsp0 got=%h want=eff17f22", rsp_dat[0]); end
    total++; if (rsp_dat[1] !== 32'hABCD3344) begin bad++; $display("FAIL b2b_rsp1 got=%h want=abcd3344", rsp_dat[1]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0] = 32'h11223344;
    mem[1] = 32'h80F17F22;
    test_reset;
    test_loads;
    test_stores;
    test_errors;
    test_reset_abort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
